ex_muldiv_ctrl: RTL and testbench
=================================

EX_MULDIV_CTRL -- requirements
Module: ex_muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1; asynchronous, active-low.
REQ-003 SHALL have port md_start, input, 1; the EX instruction is MULT/MULTU/DIV/DIVU.
REQ-004 SHALL have port md_op, input, 2; 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
REQ-005 SHALL have port md_a, input, 32; forwarded rs operand.
REQ-006 SHALL have port md_b, input, 32; forwarded rt operand.
REQ-007 SHALL have port hilo_rd, input, 1; the EX instruction is MFHI/MFLO.
REQ-008 SHALL have ports hi_wr and lo_wr, input, 1 each; the EX instruction is MTHI/MTLO, with data on md_a.
REQ-009 SHALL have port flush, input, 1; aborts any operation in progress.
REQ-010 SHALL have port busy, output, 1; an operation is in progress.
REQ-011 SHALL have port stall, output, 1; holds the IF/ID/EX stages.
REQ-012 SHALL have port done, output, 1; a one-cycle pulse when HI/LO are updated by an operation.
REQ-013 SHALL have ports hi and lo, output, 32 each; the architectural HI/LO registers.

Function
REQ-014 SHALL have states IDLE, RUN and FIX.
REQ-015 SHALL accept md_start in IDLE when flush=0 (edge E0) and latch the operand magnitudes, the operand signs and md_op.
REQ-016 SHALL perform one iteration per edge in RUN (E1..E32): shift-add for multiply, restoring shift-subtract for divide; a 6-bit counter SHALL run from 0 to 31.
REQ-017 SHALL, at E33 in FIX, apply the sign correction, write HI/LO, return to IDLE and assert done for exactly the following cycle.
REQ-018 SHALL hold busy=1 for exactly the 33 cycles between E0 and E33.
REQ-019 SHALL, for multiply, write the 64-bit product as HI=[63:32] and LO=[31:0].
REQ-020 SHALL, for divide, write LO=quotient and HI=remainder.
REQ-021 SHALL truncate the signed quotient toward zero and give the signed remainder the sign of the dividend.
REQ-022 SHALL complete a divide with md_b=0 at E1 and not enter RUN; result LO=32'hFFFFFFFF, HI=md_a; busy high 1 cycle; done pulses.
REQ-023 SHALL drive stall = busy & (md_start | hilo_rd | hi_wr | lo_wr), combinationally.
REQ-024 SHALL ignore md_start while busy=1, since the instruction is held by stall.
REQ-025 SHALL apply hi_wr/lo_wr in IDLE on the next edge; when md_start is also set, md_start wins.
REQ-026 SHALL return to IDLE on the next edge when flush=1, with HI/LO unchanged and no done pulse; flush has priority over every other input.

Reset
REQ-027 SHALL, on reset low, immediately force state=IDLE, counter=0, busy=0, done=0, stall=0, hi=0 and lo=0, regardless of any operation in progress.

Configuration
REQ-028 SHALL use macro MD_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 64-bit multiplier; HI/LO written at E1; busy high 1 cycle; done in the cycle after E1.
- Undefined: multiply is iterative per REQ-016/017.
- Divide is iterative in both cases.

Structure
REQ-029 SHALL place the op encodings, the state encoding and the constant MD_ITER=32 in shared package md_pkg.
REQ-030 SHALL place the iterative shift-add / shift-subtract datapath in sub-module md_iter_core; ex_muldiv_ctrl holds the FSM, the counter, sign handling and HI/LO.

Verification
REQ-031 SHALL cover: MULTU a=32'hFFFFFFFF, b=2 -> busy 33 cycles, then HI=1, LO=32'hFFFFFFFE, done pulse.
REQ-032 SHALL cover: MULT a=-3, b=5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; DIV a=-7, b=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-033 SHALL cover: DIVU a=9, b=0 -> busy 1 cycle; LO=32'hFFFFFFFF, HI=9.
REQ-034 SHALL cover: hilo_rd=1 at cycle 10 of a DIV -> stall=1 until busy falls; stall=0 in the done cycle.
REQ-035 SHALL cover: flush at cycle 5 of a MULT after MTHI 0x1234 -> IDLE next edge, HI=0x1234, no done; reset low mid-DIV -> all outputs 0 immediately.
REQ-036 SHALL cover: with MD_FAST_MULT_EN, MULT a=6, b=7 -> busy 1 cycle, LO=42, HI=0.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
// Optional build macro used by the unit: MD_FAST_MULT_EN.
package md_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  localparam int MD_ITER = 32;

  function automatic logic is_signed_op(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide, one step per clock.
// Result after MD_ITER steps: multiply {res_hi,res_lo}=product; divide res_hi=remainder, res_lo=quotient.
module md_iter_core
  import md_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [MD_ITER-1:0] op_a,
  input  logic [MD_ITER-1:0] op_b,
  output logic [MD_ITER-1:0] res_hi,
  output logic [MD_ITER-1:0] res_lo
);

  logic [2*MD_ITER-1:0] acc;
  logic [2*MD_ITER-1:0] acc_next;
  logic [MD_ITER-1:0]   divisor;
  logic [MD_ITER:0]     sum;
  logic [MD_ITER:0]     diff;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum  = {1'b0, acc[2*MD_ITER-1:MD_ITER]} + (acc[0] ? {1'b0, divisor} : '0);
    diff = acc[2*MD_ITER-1:MD_ITER-1] - {1'b0, divisor};
    if (is_div) begin
      if (diff[MD_ITER])
        acc_next = {acc[2*MD_ITER-2:0], 1'b0};
      else
        acc_next = {diff[MD_ITER-1:0], acc[MD_ITER-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[MD_ITER-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= {{MD_ITER{1'b0}}, op_a};
      divisor <= op_b;
    end else if (step) begin
      acc     <= acc_next;
    end
  end

  assign res_hi = acc[2*MD_ITER-1:MD_ITER];
  assign res_lo = acc[MD_ITER-1:0];

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage MULT/MULTU/DIV/DIVU controller with architectural HI/LO and pipeline stall.
// Build macro MD_FAST_MULT_EN selects a single-cycle multiplier; divide stays iterative.
module ex_muldiv_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [1:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        hilo_rd,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state, state_next;
  logic [5:0]  cnt;
  md_op_e      op_in, op_q;
  logic        in_sign_a, in_sign_b, in_div, in_zero, in_fast, start_go;
  logic [31:0] in_mag_a, in_mag_b;
  logic        sign_a_q, sign_b_q, dz_q, fast_q, div_q;
  logic [31:0] mag_a_q;
  logic [31:0] core_hi, core_lo;
  logic [63:0] fast_prod, prod, res;

  always_comb begin
    op_in     = md_op_e'(md_op);
    in_sign_a = is_signed_op(op_in) & md_a[31];
    in_sign_b = is_signed_op(op_in) & md_b[31];
    in_mag_a  = in_sign_a ? -md_a : md_a;
    in_mag_b  = in_sign_b ? -md_b : md_b;
    in_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    in_zero   = in_div && (md_b == 32'd0);
`ifdef MD_FAST_MULT_EN
    in_fast   = !in_div;
`else
    in_fast   = 1'b0;
`endif
    start_go  = (state == IDLE) && md_start && !flush;
  end

  // Divide-by-zero and fast multiply skip RUN and finish in FIX one edge later
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_go) state_next = (in_zero || in_fast) ? FIX : RUN;
      RUN: begin
        if (flush)                             state_next = IDLE;
        else if (cnt == 6'(MD_ITER - 1))       state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= '0;
      dz_q     <= 1'b0;
      fast_q   <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      if (state == RUN && !flush && cnt != 6'(MD_ITER - 1)) cnt <= cnt + 6'd1;
      else                                                  cnt <= '0;
      done <= (state == FIX) && !flush;
      if (start_go) begin
        op_q     <= op_in;
        sign_a_q <= in_sign_a;
        sign_b_q <= in_sign_b;
        mag_a_q  <= in_mag_a;
        dz_q     <= in_zero;
        fast_q   <= in_fast;
      end
      if (state == FIX && !flush) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end else if (state == IDLE && !flush && !md_start) begin
        if (hi_wr) hi <= md_a;
        if (lo_wr) lo <= md_a;
      end
    end
  end

`ifdef MD_FAST_MULT_EN
  logic [31:0] mag_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        mag_b_q <= '0;
    else if (start_go) mag_b_q <= in_mag_b;
  end

  assign fast_prod = {32'd0, mag_a_q} * {32'd0, mag_b_q};
`else
  assign fast_prod = '0;
`endif

  assign div_q = (op_q == OP_DIV) || (op_q == OP_DIVU);

  md_iter_core u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (start_go),
    .step   ((state == RUN) && !flush),
    .is_div (div_q),
    .op_a   (in_mag_a),
    .op_b   (in_mag_b),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

  // Quotient truncates toward zero; remainder takes the dividend's sign
  always_comb begin
    prod = fast_q ? fast_prod : {core_hi, core_lo};
    if (div_q) begin
      if (dz_q)
        res = {(sign_a_q ? -mag_a_q : mag_a_q), 32'hFFFF_FFFF};
      else
        res = {(sign_a_q ? -core_hi : core_hi),
               ((sign_a_q ^ sign_b_q) ? -core_lo : core_lo)};
    end else begin
      res = (sign_a_q ^ sign_b_q) ? -prod : prod;
    end
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (md_start | hilo_rd | hi_wr | lo_wr);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed testbench for ex_muldiv_ctrl: vector table for results and latency,
// plus sequences for MTHI/MTLO, flush, stall and asynchronous reset.
module tb_ex_muldiv_ctrl;
  import md_pkg::*;

`ifdef MD_FAST_MULT_EN
  localparam int     MUL_CYC  = 1;
  localparam md_op_e FLUSH_OP = OP_DIVU;
`else
  localparam int     MUL_CYC  = 33;
  localparam md_op_e FLUSH_OP = OP_MULTU;
`endif

  logic        clk = 1'b0;
  logic        reset, md_start, hilo_rd, hi_wr, lo_wr, flush;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  vec_t vecs[12];

  ex_muldiv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .hilo_rd  (hilo_rd),
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one start request; returns one step after the accepting edge
  task automatic apply_stimulus(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    md_op    = op;
    md_a     = a;
    md_b     = b;
    md_start = 1'b1;
    step_cycle();
    md_start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      step_cycle();
    end
  endtask

  initial begin
    int n;
    int stall_bad;

    vecs[0]  = '{"multu_max_x2",  OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h1,         32'hFFFF_FFFE, MUL_CYC};
    vecs[1]  = '{"mult_m3_x5",    OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_CYC};
    vecs[2]  = '{"mult_6_x7",     OP_MULT,  32'd6,         32'd7,         32'h0,         32'd42,        MUL_CYC};
    vecs[3]  = '{"mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         MUL_CYC};
    vecs[4]  = '{"mult_m1_m1",    OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1,         MUL_CYC};
    vecs[5]  = '{"multu_shift",   OP_MULTU, 32'h1234_5678, 32'h10,        32'h1,         32'h2345_6780, MUL_CYC};
    vecs[6]  = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[7]  = '{"div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD, 33};
    vecs[8]  = '{"divu_100_7",    OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    vecs[9]  = '{"divu_max_1",    OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0,         32'hFFFF_FFFF, 33};
    vecs[10] = '{"divu_9_0",      OP_DIVU,  32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, 1};
    vecs[11] = '{"div_m8_0",      OP_DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, 1};

    reset    = 1'b0;
    md_start = 1'b0;
    md_op    = 2'd0;
    md_a     = '0;
    md_b     = '0;
    hilo_rd  = 1'b0;
    hi_wr    = 1'b0;
    lo_wr    = 1'b0;
    flush    = 1'b0;

    step_cycle();
    step_cycle();
    check_output("rst_busy",  64'(busy),  64'd0);
    check_output("rst_done",  64'(done),  64'd0);
    check_output("rst_stall", 64'(stall), 64'd0);
    check_output("rst_hi",    64'(hi),    64'd0);
    check_output("rst_lo",    64'(lo),    64'd0);
    reset = 1'b1;
    step_cycle();

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      check_output({vecs[i].name, "_cycles"}, 64'(n),    64'(vecs[i].cycles));
      check_output({vecs[i].name, "_done"},   64'(done), 64'd1);
      check_output({vecs[i].name, "_hi"},     64'(hi),   64'(vecs[i].hi));
      check_output({vecs[i].name, "_lo"},     64'(lo),   64'(vecs[i].lo));
      step_cycle();
      check_output({vecs[i].name, "_done_off"}, 64'(done), 64'd0);
    end

    $display("[TB] MTHI/MTLO, start priority and flush");
    md_a  = 32'h1234;
    hi_wr = 1'b1;
    step_cycle();
    hi_wr = 1'b0;
    check_output("mthi_hi", 64'(hi), 64'h1234);
    md_a  = 32'h5678;
    lo_wr = 1'b1;
    step_cycle();
    lo_wr = 1'b0;
    check_output("mtlo_lo", 64'(lo), 64'h5678);
    check_output("mtlo_hi", 64'(hi), 64'h1234);

    hi_wr = 1'b1;
    apply_stimulus(FLUSH_OP, 32'hAAAA, 32'd3);
    check_output("start_wins_hi", 64'(hi),    64'h1234);
    check_output("start_busy",    64'(busy),  64'd1);
    check_output("mthi_stall",    64'(stall), 64'd1);
    hi_wr = 1'b0;
    repeat (4) step_cycle();
    flush = 1'b1;
    step_cycle();
    flush = 1'b0;
    check_output("flush_busy", 64'(busy), 64'd0);
    check_output("flush_done", 64'(done), 64'd0);
    check_output("flush_hi",   64'(hi),   64'h1234);
    check_output("flush_lo",   64'(lo),   64'h5678);
    step_cycle();
    check_output("flush_done2", 64'(done), 64'd0);

    $display("[TB] stall during divide");
    apply_stimulus(OP_DIV, 32'd100, 32'd3);
    repeat (3) step_cycle();
    check_output("div_nostall", 64'(stall), 64'd0);
    repeat (6) step_cycle();
    hilo_rd = 1'b1;
    #1;
    stall_bad = 0;
    n = 0;
    while (busy && n < 100) begin
      if (stall !== 1'b1) stall_bad++;
      n++;
      step_cycle();
    end
    check_output("div_stall_held", 64'(stall_bad), 64'd0);
    check_output("div_stall_busy", 64'(busy),  64'd0);
    check_output("div_stall_done", 64'(stall), 64'd0);
    check_output("div_done",       64'(done),  64'd1);
    check_output("div_lo",         64'(lo),    64'd33);
    check_output("div_hi",         64'(hi),    64'd1);
    hilo_rd = 1'b0;
    step_cycle();

    $display("[TB] reset mid-divide");
    apply_stimulus(OP_DIV, 32'd1000, 32'd7);
    repeat (5) step_cycle();
    hilo_rd = 1'b1;
    #1;
    check_output("pre_rst_stall", 64'(stall), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check_output("mid_rst_busy",  64'(busy),  64'd0);
    check_output("mid_rst_done",  64'(done),  64'd0);
    check_output("mid_rst_stall", 64'(stall), 64'd0);
    check_output("mid_rst_hi",    64'(hi),    64'd0);
    check_output("mid_rst_lo",    64'(lo),    64'd0);
    hilo_rd = 1'b0;
    step_cycle();
    reset = 1'b1;
    step_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
